apb4_ram: RTL
=============

# apb4_ram

Parametrised APB4 slave RAM, the successor to the fixed-size APB RAM used as the DUT of our APB environment. Memory width, depth and a fixed number of wait states are set by parameters. Byte-lane write strobes are optional. pslverr reports out-of-range addresses. It sits behind an APB bridge as a single-slave target and is driven directly by the existing generator/driver/monitor/scoreboard environment.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 8, paddr width; paddr is a word index, not a byte address.
- DEPTH, 64, number of words; must satisfy DEPTH <= 2**ADDR_W.
- WAIT_STATES, 0, wait cycles inserted per access, range 0..15.

Ports (one clock; reset is synchronous and active-low):
- pclk  in  1  clock; all state changes on its rising edge.
- presetn  in  1  synchronous active-low reset.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  word address.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  byte-lane write strobes; present only with APB4_RAM_PSTRB_EN.
- prdata  out  DATA_W  read data; registered.
- pready  out  1  transfer complete; registered.
- pslverr  out  1  error response; valid only while pready=1.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE → WAIT: on an edge sampling psel=1 and penable=0 (setup cycle). The edge loads a wait counter with WAIT_STATES and latches paddr, pwrite, pwdata and pstrb.
- WAIT, counter > 0: the counter decrements each edge.
- WAIT → DONE: at counter == 0. The same edge sets pready=1 and pslverr = (paddr >= DEPTH). For a read it also loads prdata with mem[paddr], or with 0 on error.
- DONE: the edge sampling psel & penable & pready completes the transfer:
  - Writes commit at this edge, unless in error.
  - pready and pslverr clear to 0; prdata holds its value.
  - The FSM returns to IDLE.
- Back-to-back: the cycle after completion may be a new setup cycle; IDLE samples it normally, so no dead cycle is added.
- Abort: psel=0 sampled in WAIT or DONE returns the FSM to IDLE. No write occurs and pready clears.
- penable=1 without a preceding setup (in IDLE) is ignored; no pready is produced.
- Error on write: memory is unchanged.
- Error on read: prdata=0.
- Reset:
  - Edge with presetn=0 sets IDLE, counter=0, pready=0, pslverr=0, prdata=0.
  - Memory contents are not cleared by reset.
  - Reset mid-transfer discards the transfer.
- Counter width is max(1, $clog2(WAIT_STATES+1)). Address comparison is unsigned, at ADDR_W width.

## Timing
- WAIT_STATES=0: setup cycle, then one access cycle with pready=1; transfer takes 2 cycles.
- WAIT_STATES=N: access phase lasts N+1 cycles; pready is high only in the last of them.
- Read data is valid in the same cycle as pready and stays stable until the next read completes.
- A write is visible to a read whose setup cycle starts in the cycle after the write completes.

## Configuration
- APB4_RAM_PSTRB_EN defined:
  - The pstrb port exists.
  - On a write, byte lane i is written only if pstrb[i]=1.
  - pstrb=0 is a legal no-op write and completes with pslverr=0.
  - pstrb is ignored on reads.
- Undefined: no pstrb port; every write updates all DATA_W bits.

## Structure
- Package apb4_ram_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - a function computing the wait-counter width;
  - localparam STRB_W = DATA_W/8 helper.
- Sub-module apb4_ram_mem holds the storage array. It provides a byte-enabled synchronous write and a read port registered into prdata by the top-level FSM. The top-level drives all-ones enables when the macro is off.

## Test plan
All scenarios use DATA_W=32, DEPTH=64, WAIT_STATES=2.
- Reset: presetn=0 for 2 cycles, psel=1 → pready=0, pslverr=0, prdata=0 throughout and 1 cycle after release.
- Write 0xDEADBEEF to addr 5, then read addr 5 → each access phase lasts exactly 3 cycles; read returns prdata=0xDEADBEEF, pslverr=0.
- With PSTRB_EN, write 0x12345678 to addr 5 with pstrb=4'b0011 → read returns 0xDEAD5678.
- Write to addr 64 → pslverr=1 with pready. Read addr 64 → prdata=0, pslverr=1. Read addr 63 → pslverr=0.
- Abort: setup a write of 0xA5A5A5A5 to addr 7, drop psel in the first wait cycle → no pready; a later read of addr 7 returns its previous value.
- Reset mid-WAIT of a write to addr 5 → pready=0 next cycle; a later read of addr 5 still returns 0xDEADBEEF.

Source files
------------

// File: rtl/apb4_ram_pkg.sv
// rtl/apb4_ram_pkg.sv - shared types and sizing helpers for apb4_ram
package apb4_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int STRB_W         = DATA_W_DEFAULT / 8;

    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb4_ram_mem.sv
// rtl/apb4_ram_mem.sv - word storage with byte-enabled synchronous write and combinational read
module apb4_ram_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (i_be[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb4_ram.sv
// rtl/apb4_ram.sv - APB4 slave RAM with fixed wait states; APB4_RAM_PSTRB_EN enables byte strobes
module apb4_ram
    import apb4_ram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB4_RAM_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int NSTRB = strb_width(DATA_W);
    localparam int CW    = cnt_width(WAIT_STATES);
    localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [NSTRB-1:0]    r_strb;
    logic                r_pready, r_pslverr;
    logic [DATA_W-1:0]   r_prdata;

    logic                w_setup, w_ack_set, w_leave_done, w_commit;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic                w_acc_write, w_acc_err;
    logic [NSTRB-1:0]    w_strb_in;
    logic [DATA_W-1:0]   w_mem_rdata;

`ifdef APB4_RAM_PSTRB_EN
    assign w_strb_in = pstrb;
`else
    assign w_strb_in = '1;
`endif

    always_ff @(posedge pclk) begin
        if (!presetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // With zero wait states the setup edge already produces the response.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (psel && !penable) w_state_nxt = (WAIT_STATES == 0) ? DONE : WAIT;
            WAIT: begin
                if (!psel)                  w_state_nxt = IDLE;
                else if (r_cnt <= CW'(1))   w_state_nxt = DONE;
            end
            DONE: if (!psel || penable) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_setup      = (r_state == IDLE) && psel && !penable;
        w_ack_set    = (w_setup && (WAIT_STATES == 0)) ||
                       ((r_state == WAIT) && psel && (r_cnt <= CW'(1)));
        w_leave_done = (r_state == DONE) && (!psel || penable);
        w_commit     = (r_state == DONE) && psel && penable && r_write && !r_pslverr;
        w_acc_addr   = (r_state == IDLE) ? paddr  : r_addr;
        w_acc_write  = (r_state == IDLE) ? pwrite : r_write;
        w_acc_err    = 32'(w_acc_addr) >= 32'(DEPTH);
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            if (w_setup) begin
                r_cnt   <= CW'(WAIT_STATES);
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= w_strb_in;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_ack_set) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_acc_err;
                if (!w_acc_write) r_prdata <= w_acc_err ? '0 : w_mem_rdata;
            end else if (w_leave_done) begin
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
            end
        end
    end

    apb4_ram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MAW)
    ) u_mem (
        .i_clk   (pclk),
        .i_we    (w_commit),
        .i_waddr (r_addr[MAW-1:0]),
        .i_wdata (r_wdata),
        .i_be    (r_strb),
        .i_raddr (w_acc_addr[MAW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule
